// File: rtl/ais_frame_builder.sv
// AIS frame builder: serialises one HDLC-style AIS frame per request.
// Frame layout: alternating preamble, 0x7E start flag, payload bytes LSB first,
// CRC-16/X-25 FCS (low byte first), 0x7E end flag. Bit stuffing covers the
// payload and FCS only. Output is NRZ; NRZI is applied downstream.
//
// Ports
//   i_clk       rising-edge clock
//   i_rst_n     synchronous active-low reset
//   i_bit_en    bit-rate strobe, one output bit per strobe while busy
//   i_start     frame request, sampled only in IDLE
//   i_len       payload byte count (1..PAR_MAX_BYTES), captured with i_start
//   i_data      payload byte
//   i_data_vld  i_data valid
//   o_data_rdy  byte buffer can take a byte
//   o_vld       o_bit valid this cycle
//   o_bit       NRZ frame bit
//   o_busy      FSM not in IDLE
//   o_done      one-cycle pulse with the last end-flag bit
//   o_err       one-cycle pulse on abort or illegal i_len
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | waiting for i_start
// PREAMBLE   | PAR_PREAMBLE_LEN alternating bits, starting with 0
// START_FLAG | 0x7E, unstuffed
// DATA       | payload bytes LSB first, stuffed, CRC accumulated
// FCS        | inverted CRC, low byte first, stuffed
// END_FLAG   | 0x7E, unstuffed, then IDLE with o_done
// ABORT      | eight unstuffed 1s after a buffer underrun, then IDLE with o_err
module ais_frame_builder #(
  parameter int PAR_PREAMBLE_LEN = 24,
  parameter int PAR_MAX_BYTES    = 21
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_bit_en,
  input  logic       i_start,
  input  logic [4:0] i_len,
  input  logic [7:0] i_data,
  input  logic       i_data_vld,
  output logic       o_data_rdy,
  output logic       o_vld,
  output logic       o_bit,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam int CNT_W = $clog2((PAR_PREAMBLE_LEN > 16) ? PAR_PREAMBLE_LEN : 16);
  localparam logic [7:0] FLAG = 8'h7E;

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, START_FLAG, DATA, FCS, END_FLAG, ABORT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [4:0]       req_left;
  logic [4:0]       load_left;
  logic [7:0]       buf_q;
  logic             buf_full;
  logic [7:0]       sh_q;
  logic [15:0]      crc_q;
  logic [2:0]       ones_cnt;
  logic             pre_bit;
  logic             fcs_tail;

  logic       byte_acc;
  logic       stuff_now;
  logic       len_ok;
  logic [2:0] flag_idx;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
    logic [15:0] sh;
    sh = {1'b0, crc[15:1]};
    return (crc[0] ^ b) ? (sh ^ 16'h8408) : sh;
  endfunction

  assign o_busy     = (state != IDLE);
  assign o_data_rdy = !buf_full && (req_left != 5'd0) &&
                      ((state == PREAMBLE) || (state == START_FLAG) || (state == DATA));
  assign byte_acc   = i_data_vld && o_data_rdy;
  assign stuff_now  = (ones_cnt == 3'd5);
  assign len_ok     = (i_len != 5'd0) && (int'(i_len) <= PAR_MAX_BYTES);
  assign flag_idx   = 3'd7 - bit_cnt[2:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      req_left  <= '0;
      load_left <= '0;
      buf_q     <= '0;
      buf_full  <= 1'b0;
      sh_q      <= '0;
      crc_q     <= 16'hFFFF;
      ones_cnt  <= '0;
      pre_bit   <= 1'b0;
      fcs_tail  <= 1'b0;
      o_vld     <= 1'b0;
      o_bit     <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_vld  <= 1'b0;
      o_done <= 1'b0;
      o_err  <= 1'b0;

      if (state == IDLE) begin
        if (i_start) begin
          if (len_ok) begin
            state     <= PREAMBLE;
            req_left  <= i_len;
            load_left <= i_len;
            bit_cnt   <= CNT_W'(PAR_PREAMBLE_LEN - 1);
            pre_bit   <= 1'b0;
            crc_q     <= 16'hFFFF;
            ones_cnt  <= '0;
            fcs_tail  <= 1'b0;
          end else begin
            o_err <= 1'b1;
          end
        end
      end else if (i_bit_en) begin
        o_vld <= 1'b1;
        case (state)
          PREAMBLE: begin
            o_bit   <= pre_bit;
            pre_bit <= ~pre_bit;
            if (bit_cnt == '0) begin
              state   <= START_FLAG;
              bit_cnt <= CNT_W'(7);
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
          START_FLAG, DATA: begin
            if (state == START_FLAG) begin
              o_bit <= FLAG[flag_idx];
            end else if (stuff_now) begin
              o_bit    <= 1'b0;
              ones_cnt <= '0;
            end else begin
              o_bit    <= sh_q[0];
              sh_q     <= {1'b0, sh_q[7:1]};
              crc_q    <= crc_step(crc_q, sh_q[0]);
              ones_cnt <= sh_q[0] ? ones_cnt + 3'd1 : 3'd0;
            end
            // Byte boundary: last flag bit or last payload bit (never a stuff bit).
            if ((state == START_FLAG || !stuff_now) && bit_cnt == '0) begin
              if (state == DATA && load_left == 5'd0) begin
                state   <= FCS;
                bit_cnt <= CNT_W'(15);
              end else if (buf_full) begin
                state     <= DATA;
                sh_q      <= buf_q;
                buf_full  <= 1'b0;
                load_left <= load_left - 5'd1;
                bit_cnt   <= CNT_W'(7);
                if (state == START_FLAG) ones_cnt <= '0;
              end else begin
                state   <= ABORT;
                bit_cnt <= CNT_W'(7);
              end
            end else if (state == START_FLAG || !stuff_now) begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
          FCS: begin
            if (stuff_now) begin
              o_bit    <= 1'b0;
              ones_cnt <= '0;
              if (fcs_tail) begin
                fcs_tail <= 1'b0;
                state    <= END_FLAG;
                bit_cnt  <= CNT_W'(7);
              end
            end else begin
              o_bit    <= ~crc_q[0];
              crc_q    <= {1'b1, crc_q[15:1]};
              ones_cnt <= ~crc_q[0] ? ones_cnt + 3'd1 : 3'd0;
              if (bit_cnt == '0) begin
                // A fifth 1 on the last FCS bit still owes its stuff bit.
                if (~crc_q[0] && ones_cnt == 3'd4) begin
                  fcs_tail <= 1'b1;
                end else begin
                  state    <= END_FLAG;
                  bit_cnt  <= CNT_W'(7);
                  ones_cnt <= '0;
                end
              end else begin
                bit_cnt <= bit_cnt - 1'b1;
              end
            end
          end
          END_FLAG: begin
            o_bit <= FLAG[flag_idx];
            if (bit_cnt == '0) begin
              state  <= IDLE;
              o_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
          ABORT: begin
            o_bit <= 1'b1;
            if (bit_cnt == '0) begin
              state <= IDLE;
              o_err <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
          default: ;
        endcase
      end

      // Last so an accept wins over a same-cycle consume of the buffer.
      if (byte_acc) begin
        buf_q    <= i_data;
        buf_full <= 1'b1;
        req_left <= req_left - 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_ais_frame_builder.sv
// Testbench for ais_frame_builder: expected bit/done/err triples are queued by
// the stimulus side, and a negedge monitor pops one per o_vld and compares.
module tb_ais_frame_builder;

  localparam int PRE  = 24;
  localparam int MAXB = 21;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_bit_en = 1'b0;
  logic       i_start = 1'b0;
  logic [4:0] i_len = '0;
  logic [7:0] i_data = '0;
  logic       i_data_vld = 1'b0;
  logic       o_data_rdy, o_vld, o_bit, o_busy, o_done, o_err;

  ais_frame_builder #(.PAR_PREAMBLE_LEN(PRE), .PAR_MAX_BYTES(MAXB)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_bit_en(i_bit_en), .i_start(i_start),
    .i_len(i_len), .i_data(i_data), .i_data_vld(i_data_vld),
    .o_data_rdy(o_data_rdy), .o_vld(o_vld), .o_bit(o_bit), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic b;
    logic d;
    logic e;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] pay[0:15];
  int total = 0, bad = 0;
  int done_cnt = 0, err_cnt = 0, bits_seen = 0;
  int ben_div = 1;
  int ones_m = 0;

  // Bit strobe: every ben_div-th cycle, or continuous when ben_div is 1.
  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge i_clk);
      #1;
      c++;
      i_bit_en = (ben_div <= 1) ? 1'b1 : ((c % ben_div) == 0);
    end
  end

  // Monitor / scoreboard
  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst_n && o_vld) begin
      bits_seen++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_bit got bit=%b done=%b err=%b", o_bit, o_done, o_err);
      end else begin
        e = exp_q.pop_front();
        if ({o_bit, o_done, o_err} !== {e.b, e.d, e.e}) begin
          bad++;
          $display("FAIL stream_bit[%0d] got bit/done/err=%b%b%b exp=%b%b%b",
                   bits_seen, o_bit, o_done, o_err, e.b, e.d, e.e);
        end
      end
    end
    if (i_rst_n && o_done && !o_vld) begin
      total++;
      bad++;
      $display("FAIL stray_done got done without vld");
    end
    if (o_done) done_cnt++;
    if (o_err) err_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic push_bit(input logic b);
    exp_t t;
    t = '{b: b, d: 1'b0, e: 1'b0};
    exp_q.push_back(t);
  endtask

  task automatic mark_last(input logic is_err);
    exp_t t;
    t = exp_q.pop_back();
    if (is_err) t.e = 1'b1;
    else t.d = 1'b1;
    exp_q.push_back(t);
  endtask

  task automatic push_stuffed(input logic b);
    push_bit(b);
    if (b) begin
      ones_m++;
      if (ones_m == 5) begin
        push_bit(1'b0);
        ones_m = 0;
      end
    end else begin
      ones_m = 0;
    end
  endtask

  task automatic push_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) push_bit(f[i]);
  endtask

  task automatic push_head();
    for (int i = 0; i < PRE; i++) push_bit(logic'(i % 2));
    push_flag();
    ones_m = 0;
  endtask

  task automatic push_fcs(input logic [15:0] fcs);
    for (int i = 0; i < 16; i++) push_stuffed(fcs[i]);
  endtask

  function automatic logic [15:0] model_fcs(input int s, input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = s; k < s + n; k++)
      for (int i = 0; i < 8; i++)
        c = (c[0] ^ pay[k][i]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    return ~c;
  endfunction

  task automatic push_frame(input int s, input int n, input logic [15:0] fcs);
    push_head();
    for (int k = s; k < s + n; k++)
      for (int i = 0; i < 8; i++) push_stuffed(pay[k][i]);
    push_fcs(fcs);
    push_flag();
    mark_last(1'b0);
  endtask

  task automatic start_frame(input int len);
    @(posedge i_clk);
    #1;
    i_start = 1'b1;
    i_len   = 5'(len);
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic feed(input int s, input int n);
    int cyc;
    for (int k = s; k < s + n; k++) begin
      i_data     = pay[k];
      i_data_vld = 1'b1;
      cyc = 0;
      @(negedge i_clk);
      while (!o_data_rdy && cyc < 4000) begin
        @(negedge i_clk);
        cyc++;
      end
      if (!o_data_rdy) begin
        total++;
        bad++;
        $display("FAIL feed_timeout got rdy=0 exp rdy=1 byte=%0d", k);
        i_data_vld = 1'b0;
        return;
      end
      @(posedge i_clk);
      #1;
    end
    i_data_vld = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int cyc;
    cyc = 0;
    @(negedge i_clk);
    while ((o_busy || exp_q.size() != 0) && cyc < budget) begin
      @(negedge i_clk);
      cyc++;
    end
    total++;
    if (o_busy || exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout got busy=%b left=%0d exp busy=0 left=0",
               name, o_busy, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_vld"},  32'(o_vld), 0);
    check({name, "_bit"},  32'(o_bit), 0);
    check({name, "_busy"}, 32'(o_busy), 0);
    check({name, "_done"}, 32'(o_done), 0);
    check({name, "_err"},  32'(o_err), 0);
    check({name, "_rdy"},  32'(o_data_rdy), 0);
  endtask

  task automatic illegal_len(input int len);
    int e0, b0;
    e0 = err_cnt;
    b0 = bits_seen;
    @(posedge i_clk);
    #1;
    i_start = 1'b1;
    i_len   = 5'(len);
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    @(negedge i_clk);
    check("illegal_err_pulse", 32'(o_err), 1);
    check("illegal_busy", 32'(o_busy), 0);
    @(negedge i_clk);
    check("illegal_err_clear", 32'(o_err), 0);
    repeat (20) @(negedge i_clk);
    check("illegal_err_count", 32'(err_cnt - e0), 1);
    check("illegal_no_bits", 32'(bits_seen - b0), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish exp finish before 2ms");
    $fatal(1);
  end

  initial begin
    int d0, e0, cyc;
    logic [7:0] s9[0:8];
    logic       hand[0:8];

    // Reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_outputs_zero("reset");
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    // "123456789", strobe every 4th cycle, FCS 0x906E (X-25 check value)
    s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    for (int k = 0; k < 9; k++) pay[k] = s9[k];
    ben_div = 4;
    d0 = done_cnt;
    push_frame(0, 9, 16'h906E);
    fork
      start_frame(9);
      feed(0, 9);
    join
    wait_idle("frame9", 4000);
    check("frame9_done_count", 32'(done_cnt - d0), 1);

    // Single 0xFF: stuff after the fifth 1
    pay[0] = 8'hFF;
    ben_div = 2;
    d0 = done_cnt;
    hand = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    push_head();
    for (int i = 0; i < 9; i++) push_bit(hand[i]);
    ones_m = 3;
    push_fcs(model_fcs(0, 1));
    push_flag();
    mark_last(1'b0);
    fork
      start_frame(1);
      feed(0, 1);
    join
    wait_idle("ff_frame", 2000);
    check("ff_done_count", 32'(done_cnt - d0), 1);

    // Underrun: len=2, only one byte supplied
    pay[0] = 8'hA5;
    ben_div = 3;
    d0 = done_cnt;
    e0 = err_cnt;
    push_head();
    for (int i = 0; i < 8; i++) push_stuffed(pay[0][i]);
    for (int i = 0; i < 8; i++) push_bit(1'b1);
    mark_last(1'b1);
    fork
      start_frame(2);
      feed(0, 1);
    join
    wait_idle("abort", 3000);
    check("abort_err_count", 32'(err_cnt - e0), 1);
    check("abort_no_done", 32'(done_cnt - d0), 0);
    check("abort_busy", 32'(o_busy), 0);
    repeat (10) @(negedge i_clk);
    check("abort_no_trailing_bits", 32'(exp_q.size()), 0);

    // Illegal lengths
    illegal_len(0);
    illegal_len(22);

    // Reset in the middle of the FCS, then a clean 0x00 frame
    pay[0] = 8'h12;
    pay[1] = 8'h34;
    pay[2] = 8'h00;
    ben_div = 2;
    push_frame(0, 2, model_fcs(0, 2));
    d0 = bits_seen;
    fork
      start_frame(2);
      feed(0, 2);
    join
    cyc = 0;
    while (bits_seen - d0 < PRE + 8 + 16 + 4 && cyc < 2000) begin
      @(negedge i_clk);
      cyc++;
    end
    check("rst_mid_reached_fcs", 32'(bits_seen - d0 >= PRE + 8 + 16 + 4), 1);
    d0 = done_cnt;
    e0 = err_cnt;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    check_outputs_zero("rst_mid");
    exp_q.delete();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    repeat (20) @(negedge i_clk);
    check("rst_mid_no_done", 32'(done_cnt - d0), 0);
    check("rst_mid_no_err", 32'(err_cnt - e0), 0);
    push_frame(2, 1, model_fcs(2, 1));
    fork
      start_frame(1);
      feed(2, 1);
    join
    wait_idle("post_rst_frame", 2000);
    check("post_rst_done_count", 32'(done_cnt - d0), 1);

    // Back-to-back frames with a continuous strobe; i_start held high so the
    // second request lands in the first IDLE cycle after frame one.
    pay[3] = 8'h7E;
    pay[4] = 8'h3C;
    pay[5] = 8'hF0;
    ben_div = 1;
    d0 = done_cnt;
    push_frame(3, 2, model_fcs(3, 2));
    push_frame(5, 1, model_fcs(5, 1));
    fork
      begin
        @(posedge i_clk);
        #1;
        i_start = 1'b1;
        i_len   = 5'd2;
        @(posedge i_clk);
        #1;
        i_len = 5'd1;
        cyc = 0;
        while (done_cnt == d0 && cyc < 2000) begin
          @(negedge i_clk);
          cyc++;
        end
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
      end
      feed(3, 3);
    join
    wait_idle("b2b", 2000);
    check("b2b_done_count", 32'(done_cnt - d0), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ais_frame_builder.md
AIS_FRAME_BUILDER -- requirements
Module: ais_frame_builder

Interface
REQ-001 SHALL have parameter PAR_PREAMBLE_LEN, default 24: number of preamble bits, alternating and starting with 0.
REQ-002 SHALL have parameter PAR_MAX_BYTES, default 21: maximum number of payload bytes per frame.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port i_bit_en, input, 1 bit: bit-rate strobe; one output bit is produced per strobe.
REQ-006 SHALL have port i_start, input, 1 bit: frame request, sampled only in IDLE.
REQ-007 SHALL have port i_len, input, 5 bits: payload byte count, captured with i_start; legal range 1..PAR_MAX_BYTES.
REQ-008 SHALL have port i_data, input, 8 bits: payload byte.
REQ-009 SHALL have port i_data_vld, input, 1 bit: i_data is valid.
REQ-010 SHALL have port o_data_rdy, output, 1 bit: byte buffer can accept a byte.
REQ-011 SHALL have port o_vld, output, 1 bit: o_bit is valid this cycle.
REQ-012 SHALL have port o_bit, output, 1 bit: NRZ frame bit; NRZI is applied downstream.
REQ-013 SHALL have port o_busy, output, 1 bit: high while the FSM is not in IDLE.
REQ-014 SHALL have port o_done, output, 1 bit: one-cycle pulse when a frame completes normally.
REQ-015 SHALL have port o_err, output, 1 bit: one-cycle pulse on abort (underrun or illegal i_len).

Function
REQ-016 SHALL implement the FSM states IDLE, PREAMBLE, START_FLAG, DATA, FCS, END_FLAG and ABORT.
REQ-017 SHALL, in IDLE, treat i_start=1 with i_len in 1..PAR_MAX_BYTES as frame accept: capture i_len and go to PREAMBLE.
REQ-018 SHALL, in IDLE, treat i_start=1 with i_len=0 or i_len>PAR_MAX_BYTES as illegal: pulse o_err next cycle and stay in IDLE.
REQ-019 SHALL advance bit state only on cycles where i_bit_en=1; with i_bit_en=0 all bit counters and the FSM hold.
REQ-020 SHALL register o_vld and o_bit so that o_vld=1 exactly in the cycle after each i_bit_en=1 while busy; latency is 1 cycle.
REQ-021 SHALL, in PREAMBLE, emit PAR_PREAMBLE_LEN bits 0,1,0,1,...
REQ-022 SHALL, in START_FLAG and END_FLAG, emit 0x7E LSB first (0,1,1,1,1,1,1,0) with no bit stuffing.
REQ-023 SHALL, in DATA, emit i_len bytes, each LSB first.
REQ-024 SHALL, in FCS, emit the 16-bit FCS: CRC-16 polynomial x^16+x^12+x^5+1, reflected, init 0xFFFF, final XOR 0xFFFF (CRC-16/X-25), computed over the unstuffed payload bits.
REQ-025 SHALL transmit the FCS low byte first, each FCS byte LSB first.
REQ-026 SHALL apply bit stuffing in DATA and FCS only: after five consecutive 1s, insert one 0 bit on the next i_bit_en.
REQ-027 SHALL, during an inserted 0 bit, not advance the payload/FCS bit counters and not update the CRC.
REQ-028 SHALL reset the ones-run counter to 0 on entry to DATA and shall not carry a run across the FCS-to-END_FLAG boundary; a stuff bit still owed after the last FCS bit SHALL be emitted before END_FLAG.
REQ-029 SHALL implement a one-byte buffer: o_data_rdy=1 when the buffer is empty, the FSM is in PREAMBLE/START_FLAG/DATA, and bytes remain to be requested.
REQ-030 SHALL accept a byte into the buffer on i_data_vld & o_data_rdy.
REQ-031 SHALL move the buffer into the shift register at each byte boundary in DATA, so a same-cycle accept and consume is legal.
REQ-032 SHALL, if the buffer is empty at a DATA byte boundary (underrun), enter ABORT: emit eight 1 bits unstuffed, then go to IDLE and pulse o_err.
REQ-033 SHALL, after the last END_FLAG bit, go to IDLE and pulse o_done in the same cycle as the final o_vld.
REQ-034 SHALL ignore i_start while busy; a new request is accepted in the first IDLE cycle.

Reset
REQ-035 SHALL, on i_rst_n=0 at a clock edge, place the FSM in IDLE and force o_vld=0, o_bit=0, o_busy=0, o_done=0, o_err=0, o_data_rdy=0.
REQ-036 SHALL, on that reset, empty the byte buffer, clear the ones-run counter and set the CRC to 0xFFFF.
REQ-037 SHALL, on reset mid-frame, abort the frame immediately with no flag or abort sequence emitted.

Verification
REQ-038 SHALL cover: i_len=9, bytes "123456789", i_bit_en every 4th cycle -> bit stream is 24-bit preamble, 0x7E, payload, FCS bytes 0x6E then 0x90, 0x7E; o_done pulses once.
REQ-039 SHALL cover: i_len=1, byte 0xFF -> DATA field bits 1,1,1,1,1,0,1,1,1 (9 bits, stuff after the fifth 1).
REQ-040 SHALL cover: i_len=2, data withheld after the first byte -> after byte 1, eight 1 bits, then o_err pulse, o_busy=0, no end flag.
REQ-041 SHALL cover: i_start with i_len=0 and with i_len=22 -> o_err pulse only, o_vld stays 0.
REQ-042 SHALL cover: i_rst_n=0 during FCS -> next cycle all outputs 0; a following frame with i_len=1, byte 0x00 is bit-exact.
REQ-043 SHALL cover: i_bit_en held continuously at 1 with back-to-back frames -> o_vld continuous, o_done and the second-frame preamble correctly sequenced, no bit lost or duplicated.
